// File: rtl/neopixel_rx.sv
// WS2812 / NeoPixel one-wire decoder: pulse-width bit slicer, 24-bit pixel framing.
// Define NEOPIXEL_RX_FORWARD_EN to model one chained pixel (pixel 0 kept, rest on dout).
module neopixel_rx #(
    parameter int T_MIN_HIGH = 3,
    parameter int T_THRESH   = 10,
    parameter int T_MAX_HIGH = 32,
    parameter int T_LATCH    = 800,
    parameter int IDX_W      = 8
) (
    input  logic             clk_16MHz,
    input  logic             rst_n,
    input  logic             din,
    output logic [23:0]      pixel_data,
    output logic             pixel_valid,
    output logic [IDX_W-1:0] pixel_index,
    output logic             frame_done,
    output logic             err,
    output logic             busy,
    output logic             dout
);

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [5:0]       MIN_H   = 6'(T_MIN_HIGH);
    localparam logic [5:0]       THR     = 6'(T_THRESH);
    localparam logic [5:0]       MAX_H   = 6'(T_MAX_HIGH);
    localparam logic [9:0]       LATCH   = 10'(T_LATCH);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic             din_m;
    logic             din_s;
    state_t           state;
    logic [5:0]       hcnt;
    logic [9:0]       lcnt;
    logic [4:0]       bitcnt;
    logic [23:0]      shreg;
    logic             pend;
    logic [IDX_W-1:0] pix_cnt;
    logic [5:0]       hcnt_inc;
    logic [9:0]       lcnt_inc;
    logic             emit;

`ifdef NEOPIXEL_RX_FORWARD_EN
    logic             fwd;
    assign emit = ~fwd;
`else
    assign emit = 1'b1;
`endif

    // Saturating increments for the width counters
    assign hcnt_inc = (hcnt == 6'd63) ? hcnt : hcnt + 6'd1;
    assign lcnt_inc = (lcnt >= LATCH) ? LATCH : lcnt + 10'd1;

    assign busy = (state == HIGH) || (state == LOW);

    // Two-flop synchronizer for the asynchronous line
    always_ff @(posedge clk_16MHz) begin
        if (!rst_n) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
        end else begin
            din_m <= din;
            din_s <= din_m;
        end
    end

    // Pulse-width FSM, bit shifter and pixel output registers
    always_ff @(posedge clk_16MHz) begin
        if (!rst_n) begin
            state       <= SYNC;
            hcnt        <= 6'd0;
            lcnt        <= 10'd0;
            bitcnt      <= 5'd0;
            shreg       <= 24'd0;
            pend        <= 1'b0;
            pix_cnt     <= '0;
            pixel_data  <= 24'd0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
`ifdef NEOPIXEL_RX_FORWARD_EN
            fwd         <= 1'b0;
`endif
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            pend        <= 1'b0;

            unique case (state)
                SYNC: begin
                    if (din_s) begin
                        lcnt <= 10'd0;
                    end else begin
                        lcnt <= lcnt_inc;
                        if (lcnt_inc == LATCH) begin
                            state <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (din_s) begin
                        state   <= HIGH;
                        hcnt    <= 6'd1;
                        bitcnt  <= 5'd0;
                        pix_cnt <= '0;
`ifdef NEOPIXEL_RX_FORWARD_EN
                        fwd     <= 1'b0;
`endif
                    end
                end
                HIGH: begin
                    if (din_s) begin
                        if (hcnt >= MAX_H) begin
                            err   <= 1'b1;
                            lcnt  <= 10'd0;
                            state <= SYNC;
                        end else begin
                            hcnt <= hcnt_inc;
                        end
                    end else if (hcnt < MIN_H) begin
                        err   <= 1'b1;
                        lcnt  <= 10'd0;
                        state <= SYNC;
                    end else begin
                        shreg  <= {shreg[22:0], (hcnt >= THR)};
                        bitcnt <= bitcnt + 5'd1;
                        lcnt   <= 10'd1;
                        state  <= LOW;
                        if (bitcnt == 5'd23) begin
                            pend <= 1'b1;
                        end
                    end
                end
                LOW: begin
                    if (din_s) begin
                        hcnt  <= 6'd1;
                        state <= HIGH;
                    end else begin
                        lcnt <= lcnt_inc;
                        if (lcnt_inc == LATCH) begin
                            frame_done <= 1'b1;
                            err        <= (bitcnt != 5'd0);
                            state      <= IDLE;
                        end
                    end
                end
            endcase

            // A pixel finished on the previous edge; publish it here
            if (pend) begin
                bitcnt  <= 5'd0;
                pix_cnt <= pix_cnt + IDX_ONE;
                if (emit) begin
                    pixel_data  <= shreg;
                    pixel_valid <= 1'b1;
                    pixel_index <= pix_cnt;
                end
`ifdef NEOPIXEL_RX_FORWARD_EN
                fwd <= 1'b1;
`endif
            end
        end
    end

`ifdef NEOPIXEL_RX_FORWARD_EN
    // Re-time the line to the next pixel once our own 24 bits are consumed
    always_ff @(posedge clk_16MHz) begin
        if (!rst_n) begin
            dout <= 1'b0;
        end else begin
            dout <= fwd && (state == HIGH || state == LOW) && din_s;
        end
    end
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_neopixel_rx.sv
// Directed bench for neopixel_rx: expected strobes queued by the stimulus,
// popped and compared by an independent monitor on the falling clock edge.
`timescale 1ns/1ps
module tb_neopixel_rx;

    localparam int K_PIX   = 0;
    localparam int K_FD    = 1;
    localparam int K_ERR   = 2;
    localparam int K_FDERR = 3;

`ifdef NEOPIXEL_RX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  kind;
        logic [23:0] data;
        logic [7:0]  idx;
    } ev_t;

    logic        clk_16MHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [7:0]  pixel_index;
    logic        frame_done;
    logic        err;
    logic        busy;
    logic        dout;

    int  vectors = 0;
    int  miscompares = 0;
    ev_t q[$];

    always #31.25 clk_16MHz = ~clk_16MHz;

    neopixel_rx dut (
        .clk_16MHz   (clk_16MHz),
        .rst_n       (rst_n),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .err         (err),
        .busy        (busy),
        .dout        (dout)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [23:0] d, input int idx);
        ev_t e;
        e.kind = 2'(kind);
        e.data = d;
        e.idx  = 8'(idx);
        q.push_back(e);
    endtask

    task automatic low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk_16MHz);
    endtask

    task automatic send_bit(input int w, input int per);
        din = 1'b1;
        repeat (w) @(negedge clk_16MHz);
        din = 1'b0;
        repeat (per - w) @(negedge clk_16MHz);
    endtask

    // Send the top n bits of d, MSB first
    task automatic send_bits(input logic [23:0] d, input int n, input int w1,
                             input int w0, input int per);
        for (int i = 23; i > 23 - n; i--) begin
            send_bit(d[i] ? w1 : w0, per);
        end
    endtask

    task automatic send_pixel(input logic [23:0] d);
        send_bits(d, 24, 14, 7, 21);
    endtask

    // Monitor: every strobe must match the head of the expectation queue
    always @(negedge clk_16MHz) begin
        if (pixel_valid || frame_done || err) begin
            ev_t o;
            ev_t e;
            o.data = pixel_data;
            o.idx  = pixel_index;
            if (pixel_valid) o.kind = 2'(K_PIX);
            else if (frame_done && err) o.kind = 2'(K_FDERR);
            else if (frame_done) o.kind = 2'(K_FD);
            else o.kind = 2'(K_ERR);
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: got kind %0d data %h idx %0d expected none",
                         o.kind, o.data, o.idx);
            end else begin
                e = q.pop_front();
                if (o.kind != e.kind ||
                    (e.kind == 2'(K_PIX) && (o.data != e.data || o.idx != e.idx))) begin
                    miscompares++;
                    $display("FAIL strobe: got kind %0d data %h idx %0d expected kind %0d data %h idx %0d",
                             o.kind, o.data, o.idx, e.kind, e.data, e.idx);
                end
            end
        end
    end

`ifdef NEOPIXEL_RX_FORWARD_EN
    logic [23:0] pixel_data2;
    logic        pixel_valid2;
    logic [7:0]  pixel_index2;
    logic        frame_done2;
    logic        err2;
    logic        busy2;
    logic        dout2;
    ev_t         q2[$];
    bit          watch_dout = 1'b0;
    bit          dout_seen = 1'b0;

    neopixel_rx dut2 (
        .clk_16MHz   (clk_16MHz),
        .rst_n       (rst_n),
        .din         (dout),
        .pixel_data  (pixel_data2),
        .pixel_valid (pixel_valid2),
        .pixel_index (pixel_index2),
        .frame_done  (frame_done2),
        .err         (err2),
        .busy        (busy2),
        .dout        (dout2)
    );

    always @(negedge clk_16MHz) begin
        if (watch_dout && dout) dout_seen = 1'b1;
        if (pixel_valid2) begin
            ev_t e;
            vectors++;
            if (q2.size() == 0) begin
                miscompares++;
                $display("FAIL chained_pixel: got %h idx %0d expected none",
                         pixel_data2, pixel_index2);
            end else begin
                e = q2.pop_front();
                if (pixel_data2 != e.data || pixel_index2 != e.idx) begin
                    miscompares++;
                    $display("FAIL chained_pixel: got %h idx %0d expected %h idx %0d",
                             pixel_data2, pixel_index2, e.data, e.idx);
                end
            end
        end
    end
`endif

    initial begin
        // Reset state
        repeat (5) @(negedge clk_16MHz);
        check("reset_outputs",
              64'({pixel_data, pixel_index, pixel_valid, frame_done, err, busy, dout}),
              64'd0);
        rst_n = 1'b1;
        low(850);

        // Single pixel
        push(K_PIX, 24'hA5C3F0, 0);
        push(K_FD, 24'h0, 0);
        send_pixel(24'hA5C3F0);
        low(850);
        check("idle_not_busy", 64'(busy), 64'd0);

        // Three pixels in one frame
        push(K_PIX, 24'hFF0000, 0);
        if (!FWD) push(K_PIX, 24'h00FF00, 1);
        if (!FWD) push(K_PIX, 24'h0000FF, 2);
        push(K_FD, 24'h0, 0);
`ifdef NEOPIXEL_RX_FORWARD_EN
        push(K_PIX, 24'h00FF00, 0);
        q2.push_back(q.pop_back());
        push(K_PIX, 24'h0000FF, 1);
        q2.push_back(q.pop_back());
`endif
        send_pixel(24'hFF0000);
        check("busy_pix0", 64'(busy), 64'd1);
        send_pixel(24'h00FF00);
        check("busy_pix1", 64'(busy), 64'd1);
        send_pixel(24'h0000FF);
        check("busy_pix2", 64'(busy), 64'd1);
        low(850);
        check("hold_data", 64'(pixel_data), 64'h0000FF & {64{!FWD}} | 64'hFF0000 & {64{FWD}});

        // Threshold: 10-high is 1, 9-high is 0
        push(K_PIX, 24'hA5A5A5, 0);
        push(K_FD, 24'h0, 0);
        send_bits(24'hA5A5A5, 24, 10, 9, 21);
        low(850);

        // Extremes accepted: 32-high and 3-high
        push(K_PIX, 24'hC3C3C3, 0);
        push(K_FD, 24'h0, 0);
        send_bits(24'hC3C3C3, 24, 32, 3, 40);
        low(850);

        // 2-cycle glitch -> error, then a frame without a fresh latch is ignored
        push(K_ERR, 24'h0, 0);
        send_bit(2, 21);
        low(20);
        check("glitch_not_busy", 64'(busy), 64'd0);
        send_pixel(24'h111111);
        low(850);
        check("hold_after_err", 64'(pixel_data), 64'hC3C3C3);

        // 33-cycle high -> error
        push(K_ERR, 24'h0, 0);
        send_bit(33, 40);
        low(850);

        push(K_PIX, 24'h0F0F0F, 0);
        push(K_FD, 24'h0, 0);
        send_pixel(24'h0F0F0F);
        low(850);

        // Partial pixel: frame_done and err together, nothing published
        push(K_FDERR, 24'h0, 0);
        send_bits(24'hABC000, 12, 14, 7, 21);
        low(850);
        push(K_PIX, 24'h5A5A5A, 0);
        push(K_FD, 24'h0, 0);
        send_pixel(24'h5A5A5A);
        low(850);

        // Reset after bit 10 of a pixel; remainder ignored
        send_bits(24'hFFFFFF, 10, 14, 7, 21);
        rst_n = 1'b0;
        @(negedge clk_16MHz);
        check("midreset_outputs",
              64'({pixel_data, pixel_index, pixel_valid, frame_done, err, busy, dout}),
              64'd0);
        rst_n = 1'b1;
        send_bits(24'hFFFFFF, 14, 14, 7, 21);
        low(850);
        push(K_PIX, 24'h3C3C3C, 0);
        push(K_FD, 24'h0, 0);
        send_pixel(24'h3C3C3C);
        low(850);

`ifdef NEOPIXEL_RX_FORWARD_EN
        // Chained pixel: first pixel kept, second forwarded
        push(K_PIX, 24'h123456, 0);
        push(K_FD, 24'h0, 0);
        push(K_PIX, 24'h789ABC, 0);
        q2.push_back(q.pop_back());
        watch_dout = 1'b1;
        send_pixel(24'h123456);
        watch_dout = 1'b0;
        check("dout_quiet_first_pixel", 64'(dout_seen), 64'd0);
        send_pixel(24'h789ABC);
        low(850);
        check("chain_queue_empty", 64'(q2.size()), 64'd0);
`else
        check("dout_tied_low", 64'(dout), 64'd0);
`endif

        low(10);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/neopixel_rx.md
Name: neopixel_rx

Overview:
- WS2812/NeoPixel serial decoder; the receive end of the one-wire pixel stream produced by the team's NeoPixel transmitter.
- Samples a single-wire data line on `clk_16MHz` and measures each high-pulse width to decode bits.
- Assembles bits MSB-first into 24-bit pixel words and flags frame latch (long low) plus protocol errors.
- Used for loopback self-test of the transmitter and as a pixel-stream sniffer / chained-pixel model.

Parameters:
- `T_MIN_HIGH`, 3: high pulses shorter than this many cycles are glitches (error).
- `T_THRESH`, 10: high width >= `T_THRESH` decodes as 1, otherwise 0.
- `T_MAX_HIGH`, 32: high width > `T_MAX_HIGH` is an error.
- `T_LATCH`, 800: low run >= `T_LATCH` cycles (50 us @ 16 MHz) ends a frame.
- `IDX_W`, 8: width of the pixel index counter.

Ports:
- `clk_16MHz`, input, 1: system clock, 16 MHz.
- `rst_n`, input, 1: synchronous reset, active-low.
- `din`, input, 1: asynchronous serial pixel line.
- `pixel_data`, output, 24: last completed pixel word, bit 23 = first bit received.
- `pixel_valid`, output, 1: one-cycle strobe when `pixel_data` is updated.
- `pixel_index`, output, `IDX_W`: index within the frame of the pixel in `pixel_data`, 0 = first.
- `frame_done`, output, 1: one-cycle strobe on latch detection after at least one bit.
- `err`, output, 1: one-cycle strobe on protocol error.
- `busy`, output, 1: high while a frame is being received (state HIGH or LOW).
- `dout`, output, 1: forwarded line (see Optional Feature).

Behaviour:
- **Reset.** While `rst_n` = 0 at a rising edge, all outputs are 0, all counters are 0, and state = SYNC.
- **Input synchronizer.** `din` passes through 2 flops to form `din_s`; all timing below refers to `din_s`.
- **Width counters.**
  - Width counter `hcnt` is 6 bits and saturates at 63.
  - Low counter `lcnt` is 10 bits and saturates at `T_LATCH`.
- **States.**
  - SYNC: wait for `din_s` low for `T_LATCH` consecutive cycles, then go to IDLE. Ensures the block never starts mid-frame.
  - IDLE: when `din_s` = 1, go to HIGH with `hcnt` = 1, `bitcnt` = 0, `pixel_index` count = 0.
  - HIGH: `hcnt`++ while `din_s` = 1.
    - If `hcnt` exceeds `T_MAX_HIGH`: pulse `err`, go to SYNC.
    - On `din_s` = 0 with `hcnt` < `T_MIN_HIGH`: pulse `err`, go to SYNC.
    - On `din_s` = 0 otherwise: shift bit (`hcnt` >= `T_THRESH`) into the 24-bit shift register, `bitcnt`++, `lcnt` = 1, go to LOW.
  - LOW: `lcnt`++ while `din_s` = 0.
    - On `din_s` = 1: `hcnt` = 1, go to HIGH.
    - When `lcnt` reaches `T_LATCH`: pulse `frame_done`, go to IDLE. If `bitcnt` != 0, also pulse `err` in the same cycle (partial pixel discarded).
- **Pixel completion.**
  - When the 24th bit shifts in, on the next edge: `pixel_data` <= shift value, `pixel_valid` = 1 for one cycle, `pixel_index` <= current count, then count++ and `bitcnt` = 0.
  - The count wraps modulo 2^`IDX_W`.
- **Latency.** `pixel_valid` rises 4 clocks after the final falling edge of the 24th bit on `din`: 2 synchronizer flops, 1 for the HIGH→LOW decision, 1 for the register update.
- **Hold.** `pixel_data` and `pixel_index` hold until the next `pixel_valid`.
- **`busy`.** `busy` = 1 in HIGH and LOW, 0 in SYNC and IDLE.
- **Mid-operation reset.** `rst_n` low mid-frame aborts immediately; no strobes are emitted. After release the block starts in SYNC, so the remainder of that frame is ignored.
- **Simultaneous events.** When `err` and `frame_done` fire together, both are asserted.
- **Transmitter compatibility.** The team transmitter's timing (1 = 14 high / 21 period, 0 = 7 high / 21 period) decodes with margin under the default parameters.

Optional Feature:
- Macro: `NEOPIXEL_RX_FORWARD_EN`.
- Defined: the block models one chained WS2812 pixel.
  - Only pixel 0 of each frame produces `pixel_valid`; later pixels do not update `pixel_data`.
  - `dout` is held 0 during the first 24 bits.
  - From bit 25 until latch, `dout` = `din_s` delayed by 1 cycle. Pulse widths are preserved exactly.
  - `dout` = 0 in SYNC and IDLE.
- Undefined: `dout` is tied to 0, and every pixel in the frame produces `pixel_valid`.

Test Plan:
- **Single pixel.** Reset, `din` low 800 cycles, one pixel 0xA5C3F0 using 14/7-high, 21-cycle bits, then low 800 → `pixel_valid` once with `pixel_data` = 0xA5C3F0, `pixel_index` = 0, then `frame_done` 1 cycle, `err` never.
- **Three pixels.** 0xFF0000, 0x00FF00, 0x0000FF then latch → three `pixel_valid` strobes with indices 0, 1, 2 and matching data; `busy` high throughout the frame.
- **Threshold boundaries.** Bits with high widths 9 and 10 cycles → decoded 0 and 1 respectively. A 2-cycle high → `err`, state SYNC, and no `pixel_valid` until a fresh 800-cycle low is followed by a new frame.
- **Partial pixel.** 12 bits then 800 low → `frame_done` and `err` in the same cycle, no `pixel_valid`. The next full pixel after latch decodes at index 0.
- **Reset mid-frame.** Assert `rst_n` = 0 for 1 cycle after bit 10 of a pixel → all outputs 0. The remaining bits are ignored; the next frame after an 800-cycle low decodes correctly.
- **Forward mode** (`NEOPIXEL_RX_FORWARD_EN`). Send 2 pixels 0x123456, 0x789ABC → `pixel_valid` only for 0x123456. `dout` stays 0 for the first 24 bits, then reproduces the second pixel's pulses 1 cycle after `din_s`; a second `neopixel_rx` on `dout` decodes 0x789ABC.
